// File: rtl/div_iter.sv
// div_iter: iterative 32-bit divider (DIV / DIVU).
// One restoring shift-subtract step per cycle. The quotient lands in result[31:0]
// (LO) and the remainder in result[63:32] (HI). Signed operands are divided as
// magnitudes, and the recorded signs are applied when the result is registered.
//
// Handshake: the requester raises `start` with the operands and holds it until
// `ready` is seen. Operands are captured on the edge that leaves IDLE.
// `ready` is high only in END, where `result` is stable. The block stays in END
// while `start` is high and returns to IDLE on the first cycle `start` is low.
// `annul` aborts any operation at the next edge and takes priority over `start`.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic [1:0]  stateDbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } stateT;

    stateT       state;
    stateT       nextState;

    logic [64:0] work;        // {remainder[64:32], dividend/quotient[31:0]}
    logic [5:0]  cnt;         // iteration index 0..31
    logic [31:0] divisor;     // divisor magnitude
    logic        signedLat;
    logic        sign1Lat;
    logic        sign2Lat;

    logic [31:0] absOp1;
    logic [31:0] absOp2;
    logic [64:0] shifted;
    logic [33:0] diff;
    logic [64:0] stepWork;
    logic        negQuot;
    logic        negRem;
    logic [31:0] quotMag;
    logic [31:0] remMag;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;
    logic        lastStep;

    assign stateDbg = state;

    // Operand magnitudes and one restoring step of the working register.
    always_comb begin
        absOp1    = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
        absOp2    = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;
        shifted   = work << 1;
        diff      = {1'b0, shifted[64:32]} - {2'b00, divisor};
        stepWork  = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
        negQuot   = signedLat & (sign1Lat ^ sign2Lat);
        negRem    = signedLat & sign1Lat;
        quotMag   = stepWork[31:0];
        remMag    = stepWork[63:32];
        quotFinal = negQuot ? (32'd0 - quotMag) : quotMag;
        remFinal  = negRem ? (32'd0 - remMag) : remMag;
        lastStep  = (cnt == 6'd31);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. In every state other than IDLE, annul wins.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (annul)                           nextState = IDLE;
                else if (start && opdata2 == 32'd0)  nextState = BYZERO;
                else if (start)                      nextState = ON;
                else                                 nextState = IDLE;
            end
            BYZERO: nextState = annul ? IDLE : END;
            ON: begin
                if (annul)         nextState = IDLE;
                else if (lastStep) nextState = END;
                else               nextState = ON;
            end
            END: begin
                if (annul)      nextState = IDLE;
                else if (start) nextState = END;
                else            nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work      <= '0;
            cnt       <= '0;
            divisor   <= '0;
            signedLat <= 1'b0;
            sign1Lat  <= 1'b0;
            sign2Lat  <= 1'b0;
            result    <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= (nextState == END);
            case (state)
                IDLE: begin
                    if (!annul && start) begin
                        signedLat <= signed_div;
                        sign1Lat  <= opdata1[31];
                        sign2Lat  <= opdata2[31];
                        divisor   <= absOp2;
                        work      <= {33'd0, absOp1};
                        cnt       <= '0;
                    end
                end
                BYZERO: begin
                    if (annul) begin
                        work <= '0;
                        cnt  <= '0;
                    end else begin
                        result <= '0;
                    end
                end
                ON: begin
                    if (annul) begin
                        work <= '0;
                        cnt  <= '0;
                    end else begin
                        work <= stepWork;
                        if (lastStep) begin
                            cnt    <= '0;
                            result <= {remFinal, quotFinal};
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                END: begin
                    if (annul) begin
                        work <= '0;
                        cnt  <= '0;
                    end
                end
                default: begin
                    work <= '0;
                    cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: a directed vector table, hand-written multi-cycle corner
// sequences, and random operations checked against an arithmetic model.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic [1:0]  stateDbg;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vecT;

    vecT vecs[$];

    div_iter dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stateDbg   (stateDbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, truncating toward zero; divide by zero gives 0.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one divide, measure latency from the start cycle, check the result,
    // then release start and confirm the return to IDLE.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit holdStart);
        int  lat;
        int  expLat;
        bit  seen;
        logic [63:0] got;
        expLat     = (b == 32'd0) ? 2 : 33;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        lat        = 0;
        seen       = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            // Operands are captured; later values must be ignored.
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
            if (!holdStart) start = 1'b0;
            if (ready) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'(expLat));
        got = seen ? result : ~exp;
        check({name, " result"}, got, exp);
        if (holdStart) begin
            tick();
            check({name, " held ready"}, {63'd0, ready}, 64'd1);
            check({name, " held result"}, result, exp);
            start = 1'b0;
        end
        tick();
        check({name, " ready drop"}, {63'd0, ready}, 64'd0);
        check({name, " idle after"}, {62'd0, stateDbg}, 64'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;

        vecs.push_back('{"u100_7",     1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}});
        vecs.push_back('{"s-7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD}});
        vecs.push_back('{"s7_-2",      1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD}});
        vecs.push_back('{"s_min_-1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000}});
        vecs.push_back('{"u_min_max",  1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000,   32'd0}});
        vecs.push_back('{"u5_0",       1'b0, 32'd5,          32'd0,          64'd0});
        vecs.push_back('{"s-5_0",      1'b1, 32'hFFFFFFFB,   32'd0,          64'd0});
        vecs.push_back('{"s-7_-2",     1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF,   32'd3}});
        vecs.push_back('{"u3_10",      1'b0, 32'd3,          32'd10,         {32'd3,          32'd0}});

        // reset state
        #12;
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        check("reset state", {62'd0, stateDbg}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("idle ready", {63'd0, ready}, 64'd0);

        // directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
        end

        // start dropped during ON does not abort
        run_op("drop_start", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 1'b0);

        // annul beats start in IDLE
        begin
            signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3;
            start = 1'b1; annul = 1'b1;
            tick();
            check("annul_idle state", {62'd0, stateDbg}, 64'd0);
            start = 1'b0; annul = 1'b0;
            tick();
        end

        // annul pulsed at step 10 of ON: ready must never rise for that op
        begin
            bit sawReady;
            signed_div = 1'b0; opdata1 = 32'd1234; opdata2 = 32'd5;
            start = 1'b1;
            tick();
            for (int i = 0; i < 10; i++) tick();
            annul = 1'b1; start = 1'b0;
            tick();
            annul = 1'b0;
            check("annul_on state", {62'd0, stateDbg}, 64'd0);
            sawReady = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (ready) sawReady = 1'b1;
                tick();
            end
            check("annul_on no ready", {63'd0, sawReady}, 64'd0);
            run_op("after_annul", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b1);
        end

        // annul in END returns to IDLE even with start still high
        begin
            signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd0;
            start = 1'b1;
            tick();
            tick();
            check("end ready", {63'd0, ready}, 64'd1);
            annul = 1'b1;
            tick();
            annul = 1'b0; start = 1'b0;
            check("annul_end ready", {63'd0, ready}, 64'd0);
            check("annul_end state", {62'd0, stateDbg}, 64'd0);
        end

        // random operations against the model
        for (int n = 0; n < 40; n++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2, 3, 4: b = 32'($urandom_range(1, 300));
                default: b = 32'($urandom);
            endcase
            run_op($sformatf("rand%0d", n), sgn, a, b, model(sgn, a, b), 1'($urandom_range(0, 1)));
        end

        // prime result with a nonzero value before the reset test
        run_op("pre_reset", 1'b0, 32'd77, 32'd7, {32'd0, 32'd11}, 1'b1);

        // asynchronous reset at step 20 of ON
        begin
            bit sawReady;
            signed_div = 1'b0; opdata1 = 32'd999; opdata2 = 32'd4;
            start = 1'b1;
            tick();
            for (int i = 0; i < 20; i++) tick();
            #2;
            rst = 1'b0;
            #1;
            check("async rst ready", {63'd0, ready}, 64'd0);
            check("async rst result", result, 64'd0);
            check("async rst state", {62'd0, stateDbg}, 64'd0);
            start = 1'b0;
            tick();
            rst = 1'b1;
            sawReady = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (ready) sawReady = 1'b1;
            end
            check("post rst no ready", {63'd0, sawReady}, 64'd0);
            check("post rst state", {62'd0, stateDbg}, 64'd0);
            run_op("post_rst_op", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 The block SHALL have a port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port `rst`, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have a port `signed_div`, input, 1 bit: 1 selects a signed divide (DIV), 0 an unsigned divide (DIVU).
REQ-005 The block SHALL have a port `opdata1`, input, 32 bits: the dividend.
REQ-006 The block SHALL have a port `opdata2`, input, 32 bits: the divisor.
REQ-007 The block SHALL have a port `start`, input, 1 bit: a request to begin a divide, held high by the execute stage until `ready` is seen.
REQ-008 The block SHALL have a port `annul`, input, 1 bit: abort of any operation in flight, driven by the execute-stage flush.
REQ-009 The block SHALL have a port `result`, output, 64 bits: {remainder[63:32] for HI, quotient[31:0] for LO}.
REQ-010 The block SHALL have a port `ready`, output, 1 bit: `result` is valid this cycle.

Function
REQ-011 The block SHALL implement a four-state FSM: IDLE, BYZERO, ON, END.
REQ-012 IDLE SHALL behave as follows: if `annul`=1, stay in IDLE (annul beats start); else if `start`=1 and `opdata2`==0, go to BYZERO; else if `start`=1, go to ON; else stay in IDLE.
REQ-013 On the IDLE->ON or IDLE->BYZERO transition, the block SHALL latch `signed_div`, `opdata1` and `opdata2`; operand changes after this edge SHALL be ignored.
REQ-014 In signed mode, the block SHALL latch the magnitude of each negative operand (two's complement) and record the sign of the quotient (sign1 XOR sign2) and the sign of the remainder (sign1).
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit working register, with a 6-bit iteration counter running 0..31.
REQ-016 After the 32nd step the block SHALL go to END, counter reset to 0.
REQ-017 On entry to END, the block SHALL apply the recorded signs by negating the quotient and/or remainder as needed, and register the result into `result`.
REQ-018 BYZERO SHALL last exactly one cycle and then go to END with `result`=64'h0.
REQ-019 In END, `ready` SHALL be 1 and `result` SHALL be stable; the block SHALL stay in END while `start`=1 and go to IDLE when `start`=0.
REQ-020 `ready` SHALL be registered and equal to 1 only in state END.
REQ-021 Latency: with `start` first seen high in IDLE in cycle 0 and divisor nonzero, `ready` SHALL rise in cycle 33. For a zero divisor, `ready` SHALL rise in cycle 2.
REQ-022 `annul`=1 in BYZERO, ON or END SHALL force IDLE at the next edge: `ready`=0, counter=0, working register cleared. A new `start` after the annul SHALL take the full latency again.
REQ-023 Deasserting `start` during BYZERO or ON SHALL NOT abort the operation; only `annul` aborts.
REQ-024 Outside END, `result` SHALL hold its last value and is defined as don't-care to consumers.
REQ-025 Signed -2^31 / -1 SHALL produce quotient 32'h80000000 and remainder 0, with no exception (two's-complement wrap).
REQ-026 Signed results SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.

Reset
REQ-027 `rst`=0 SHALL immediately, without waiting for `clk`, force state IDLE, `ready`=0, `result`=64'h0, counter=0 and all latched operands/signs=0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; after release, `ready` SHALL stay 0 until a fresh `start`.

Verification
REQ-029 The bench SHALL cover unsigned 100/7: `start`=1 held -> `ready`=1 in cycle 33, `result`={32'd2, 32'd14}; drop `start` -> `ready`=0 next cycle.
REQ-030 The bench SHALL cover signed -7/2 (32'hFFFFFFF9 / 2): -> `result`={32'hFFFFFFFF, 32'hFFFFFFFD}; also signed 7/-2 -> {32'd1, 32'hFFFFFFFD}.
REQ-031 The bench SHALL cover divide by zero, 5/0 unsigned: -> `ready`=1 in cycle 2, `result`=64'h0.
REQ-032 The bench SHALL cover an annul mid-run: `annul` pulsed in ON at step 10 -> `ready` never rises for that op. A new 0xFFFFFFFF/1 unsigned op then gives `ready` in cycle 33 and `result`={32'h0, 32'hFFFFFFFF}.
REQ-033 The bench SHALL cover the corner case signed 32'h80000000 / 32'hFFFFFFFF: -> `result`={32'h0, 32'h80000000}.
REQ-034 The bench SHALL cover reset asynchronously: `rst` driven low at step 20 of ON -> `ready`=0 and `result`=0 before the next `clk` edge, and the FSM is in IDLE after release.
